// File: rtl/walk_register_pkg.sv
// walk_register_pkg: walk-request encoding shared by the latch and the controller FSM
package walk_register_pkg;
  // Clear over set: WR_Reset at an edge discards any simultaneous WR_Sync, and that request is not remembered.
  localparam logic WR_IDLE = 1'b0;
  localparam logic WR_PENDING = 1'b1;
  function automatic logic wr_next(input logic wr, input logic clr, input logic req);
    return clr ? WR_IDLE : req ? WR_PENDING : wr;
  endfunction
endpackage

// File: rtl/walk_register.sv
// walk_register: sticky walk-request flag, set by WR_Sync and cleared by WR_Reset
module walk_register
  import walk_register_pkg::*;
#(
  parameter logic INIT_VALUE = WR_IDLE
) (
  input  logic clock,
  input  logic WR_Reset,
  input  logic WR_Sync,
  output logic WR
);
  logic wr_q = INIT_VALUE;
  logic clr_d = 1'b0;
  logic wr_d = INIT_VALUE;
  always_ff @(posedge clock) wr_q <= wr_next(wr_q, WR_Reset, WR_Sync);
  assign WR = wr_q;
  // History of the previous edge, used only by the checks below
  always_ff @(posedge clock) begin
    clr_d <= WR_Reset;
    wr_d <= wr_q;
    if (clr_d) assert (wr_q == WR_IDLE) else $error("walk_register: WR set after a clear edge");
    if (wr_d && !wr_q) assert (clr_d) else $error("walk_register: WR fell without a clear");
  end
endmodule

// File: tb/tb_walk_register.sv
// tb_walk_register: directed and random checks of the walk-request latch against a pending-request model
module tb_walk_register;
  logic clock = 1'b0;
  logic WR_Reset = 1'b0;
  logic WR_Sync = 1'b0;
  logic WR;
  logic exp_wr = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  walk_register dut (.clock(clock), .WR_Reset(WR_Reset), .WR_Sync(WR_Sync), .WR(WR));

  always #10 clock = ~clock;

  task automatic check(input string tag);
    vectors++;
    assert (WR === exp_wr) else begin
      miscompares++;
      $error("FAIL %s t=%0t: WR=%b expected %b", tag, $time, WR, exp_wr);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then compare 1 ns later
  task automatic step(input logic clr, input logic req, input string tag);
    WR_Reset = clr;
    WR_Sync = req;
    @(posedge clock);
    if (clr) exp_wr = 1'b0;
    else if (req) exp_wr = 1'b1;
    #1 check(tag);
  endtask

  initial begin
    #1 check("reset_state");
    WR_Reset = 1'b0;
    WR_Sync = 1'b1;
    step(1'b0, 1'b1, "set");
    if (exp_wr !== 1'b1) $fatal(1, "FAIL model: set not modelled");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "hold");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "clear_held");
    step(1'b1, 1'b1, "set_during_clear");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "clear_held2");
    step(1'b0, 1'b0, "pulse_forgotten");
    step(1'b0, 1'b0, "idle_after_clear");
    step(1'b0, 1'b1, "reset_again");
    step(1'b1, 1'b1, "simultaneous");
    step(1'b0, 1'b1, "request_after_clear");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, "idempotent_pulse");
      step(1'b0, 1'b0, "idempotent_gap");
    end
    step(1'b1, 1'b0, "single_clear");
    step(1'b0, 1'b0, "stays_clear");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, "random");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100;
    if (vectors == 0) $fatal(1, "FAIL watchdog: no vectors applied");
  end
endmodule
